// File: rtl/sfp_link_manager.sv
// Multi-channel SFP link supervisor: debounces signal-detect, reads the module-type byte over a
// shared round-robin I2C request port, selects SGMII/BASE-X and pulses PCS/PMA reset on mode change.
module sfp_link_manager #(
    parameter int         CH_NUM   = 2,
    parameter int         DEB_CYC  = 20_000_000,
    parameter int         RST_CYC  = 200_000,
    parameter int         TO_CYC   = 2_000_000,
    parameter logic [6:0] IIC_DAD  = 7'b101_0000,
    parameter logic [7:0] ADR_BASE = 8'h06,
    parameter int         MODE_BIT = 3
) (
    input  logic              CLK_200M,
    input  logic              SYS_RSTn,
    input  logic [CH_NUM-1:0] SIG_DET_IN,
    output logic              IIC_REQ_OUT,
    output logic [2:0]        IIC_CH_OUT,
    output logic [6:0]        IIC_DAD_OUT,
    output logic [7:0]        IIC_ADR_OUT,
    input  logic              IIC_ACK_IN,
    input  logic              IIC_RVL_IN,
    input  logic [7:0]        IIC_RDT_IN,
    input  logic              IIC_ERR_IN,
    output logic [CH_NUM-1:0] SEL_SGMII_OUT,
    output logic [CH_NUM-1:0] TX_DISABLE_OUT,
    output logic [CH_NUM-1:0] PHY_RST_OUT,
    output logic [CH_NUM-1:0] SIG_OK_OUT,
    output logic [CH_NUM-1:0] ID_ERR_OUT
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int RW = $clog2(RST_CYC + 1);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC - 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_APPLY = 2'd3
    } state_t;

    state_t            state_r;
    logic [CH_NUM-1:0] sync1_r, sync2_r, sig_ok_r, pend_r;
    logic [DW-1:0]     deb_cnt_r [CH_NUM];
    logic [RW-1:0]     rst_cnt_r [CH_NUM];
    logic [CH_NUM-1:0] sel_r, tx_dis_r, phy_rst_r, id_err_r;
    logic              req_r, ok_r, bit_r;
    logic [2:0]        ch_r, last_r, pick_s;
    logic [TW-1:0]     timer_r;
    logic [CH_NUM-1:0] rise_s, fall_s, ch_mask_s, reload_s, err_set_s, err_clr_s, pend_nxt_s;
    logic              apply_s;

    // Two-flop synchroniser and per-channel debounce counters
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            sync1_r  <= {CH_NUM{1'b0}};
            sync2_r  <= {CH_NUM{1'b0}};
            sig_ok_r <= {CH_NUM{1'b0}};
            for (int i = 0; i < CH_NUM; i++) deb_cnt_r[i] <= DEB_LOAD;
        end else begin
            sync1_r <= SIG_DET_IN;
            sync2_r <= sync1_r;
            for (int i = 0; i < CH_NUM; i++) begin
                if (!sync2_r[i]) begin
                    deb_cnt_r[i] <= DEB_LOAD;
                    sig_ok_r[i]  <= 1'b0;
                end else if (!sig_ok_r[i]) begin
                    if (deb_cnt_r[i] == {DW{1'b0}}) sig_ok_r[i] <= 1'b1;
                    else                            deb_cnt_r[i] <= deb_cnt_r[i] - DW'(1);
                end
            end
        end
    end

    // Qualified-detect edges, round-robin pick and apply-time decode
    always_comb begin
        rise_s = {CH_NUM{1'b0}};
        fall_s = {CH_NUM{1'b0}};
        pick_s = last_r;
        for (int i = 0; i < CH_NUM; i++) begin
            rise_s[i] = sync2_r[i] & ~sig_ok_r[i] & (deb_cnt_r[i] == {DW{1'b0}});
            fall_s[i] = ~sync2_r[i] & sig_ok_r[i];
        end
        // Scan downwards so the nearest channel after the last serviced one wins
        for (int k = CH_NUM; k >= 1; k--) begin
            pick_s = ((pend_r & (CH_NUM'(1'b1) << ((int'(last_r) + k) % CH_NUM))) != {CH_NUM{1'b0}})
                     ? 3'((int'(last_r) + k) % CH_NUM) : pick_s;
        end
        ch_mask_s  = CH_NUM'(1'b1) << ch_r;
        apply_s    = (state_r == ST_APPLY) && ((sig_ok_r & ch_mask_s) != {CH_NUM{1'b0}});
        reload_s   = (apply_s && ok_r && (bit_r != |(sel_r & ch_mask_s))) ? ch_mask_s : {CH_NUM{1'b0}};
        err_set_s  = (apply_s && !ok_r) ? ch_mask_s : {CH_NUM{1'b0}};
        err_clr_s  = (apply_s && ok_r) ? ch_mask_s : {CH_NUM{1'b0}};
        // A fresh detect in the apply cycle must survive so the module is re-read
        pend_nxt_s = ((pend_r & ~((state_r == ST_APPLY) ? ch_mask_s : {CH_NUM{1'b0}})) | rise_s) & ~fall_s;
    end

    // Shared I2C request sequencer and pending-read bookkeeping
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            ch_r    <= 3'd0;
            last_r  <= 3'(CH_NUM - 1);
            timer_r <= {TW{1'b0}};
            ok_r    <= 1'b0;
            bit_r   <= 1'b0;
            pend_r  <= {CH_NUM{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (pend_r != {CH_NUM{1'b0}}) begin
                        ch_r    <= pick_s;
                        last_r  <= pick_s;
                        req_r   <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IIC_ACK_IN) begin
                        req_r   <= 1'b0;
                        timer_r <= TO_LOAD;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IIC_RVL_IN) begin
                        ok_r    <= 1'b1;
                        bit_r   <= IIC_RDT_IN[MODE_BIT];
                        state_r <= ST_APPLY;
                    end else if (IIC_ERR_IN || (timer_r == {TW{1'b0}})) begin
                        ok_r    <= 1'b0;
                        state_r <= ST_APPLY;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                ST_APPLY: state_r <= ST_IDLE;
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Mode select, TX disable, sticky ID error and PHY reset pulse stretchers
    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            sel_r     <= {CH_NUM{1'b0}};
            tx_dis_r  <= {CH_NUM{1'b1}};
            id_err_r  <= {CH_NUM{1'b0}};
            phy_rst_r <= {CH_NUM{1'b1}};
            for (int i = 0; i < CH_NUM; i++) rst_cnt_r[i] <= RST_LOAD;
        end else begin
            sel_r    <= sel_r ^ reload_s;
            tx_dis_r <= ~(sel_r ^ reload_s);
            id_err_r <= (id_err_r | err_set_s) & ~err_clr_s;
            for (int i = 0; i < CH_NUM; i++) begin
                if (reload_s[i]) begin
                    rst_cnt_r[i] <= RST_LOAD;
                    phy_rst_r[i] <= 1'b1;
                end else if (rst_cnt_r[i] != {RW{1'b0}}) begin
                    rst_cnt_r[i] <= rst_cnt_r[i] - RW'(1);
                    phy_rst_r[i] <= (rst_cnt_r[i] != RW'(1));
                end else begin
                    phy_rst_r[i] <= 1'b0;
                end
            end
        end
    end

    assign IIC_REQ_OUT    = req_r;
    assign IIC_CH_OUT     = ch_r;
    assign IIC_DAD_OUT    = IIC_DAD;
    assign IIC_ADR_OUT    = ADR_BASE;
    assign SEL_SGMII_OUT  = sel_r;
    assign TX_DISABLE_OUT = tx_dis_r;
    assign PHY_RST_OUT    = phy_rst_r;
    assign SIG_OK_OUT     = sig_ok_r;
    assign ID_ERR_OUT     = id_err_r;

endmodule

// File: tb/tb_sfp_link_manager.sv
// Scoreboard bench for sfp_link_manager: an I2C responder pops expected reads and checks
// channel order, mode select, reset pulse width and ID error flags against a small model.
module tb_sfp_link_manager;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sig_det = 2'b00;
    logic       iic_req, iic_ack = 1'b0, iic_rvl = 1'b0, iic_err = 1'b0;
    logic [2:0] iic_ch;
    logic [6:0] iic_dad;
    logic [7:0] iic_adr, iic_rdt = 8'h00;
    logic [1:0] sel_sgmii, tx_disable, phy_rst, sig_ok, id_err;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         mode;   // 0 = data returned, 1 = I2C error, 2 = no response
        bit         drop;   // lose signal-detect while the read is in flight
    } sb_t;

    sb_t        sb_q[$];
    logic [1:0] sel_m = 2'b00, err_m = 2'b00;
    int         vec_cnt = 0, err_cnt = 0;

    sfp_link_manager #(.CH_NUM(2), .DEB_CYC(16), .RST_CYC(8), .TO_CYC(32)) dut (
        .CLK_200M(clk), .SYS_RSTn(rst_n), .SIG_DET_IN(sig_det),
        .IIC_REQ_OUT(iic_req), .IIC_CH_OUT(iic_ch), .IIC_DAD_OUT(iic_dad), .IIC_ADR_OUT(iic_adr),
        .IIC_ACK_IN(iic_ack), .IIC_RVL_IN(iic_rvl), .IIC_RDT_IN(iic_rdt), .IIC_ERR_IN(iic_err),
        .SEL_SGMII_OUT(sel_sgmii), .TX_DISABLE_OUT(tx_disable), .PHY_RST_OUT(phy_rst),
        .SIG_OK_OUT(sig_ok), .ID_ERR_OUT(id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic requal(input logic [1:0] m);
        sig_det = sig_det & ~m;
        repeat (5) @(negedge clk);
        sig_det = sig_det | m;
    endtask

    task automatic serve();
        sb_t        it;
        bit         seen;
        int         hi, exp_hi;
        logic [1:0] tx_m;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        it = sb_q.pop_front();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = iic_req;
        end
        chk("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("req_ch", 32'(iic_ch), 32'(it.ch));
        chk("req_dad", 32'(iic_dad), 32'h50);
        chk("req_adr", 32'(iic_adr), 32'h06);
        repeat (2) @(negedge clk);
        chk("req_held", 32'(iic_req), 32'd1);
        iic_ack = 1'b1;
        @(negedge clk);
        iic_ack = 1'b0;
        chk("req_drop", 32'(iic_req), 32'd0);
        if (it.drop) begin
            sig_det[it.ch] = 1'b0;
            repeat (6) @(negedge clk);
            chk("drop_sigok", 32'(sig_ok[it.ch]), 32'd0);
        end else begin
            repeat (3) @(negedge clk);
        end
        if (it.mode == 0) begin
            iic_rdt = it.data;
            iic_rvl = 1'b1;
            @(negedge clk);
            iic_rvl = 1'b0;
        end else if (it.mode == 1) begin
            iic_err = 1'b1;
            @(negedge clk);
            iic_err = 1'b0;
        end
        hi = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            hi += int'(phy_rst[it.ch]);
        end
        exp_hi = 0;
        if (!it.drop) begin
            if (it.mode != 0) err_m[it.ch] = 1'b1;
            else begin
                err_m[it.ch] = 1'b0;
                if (it.data[3] != sel_m[it.ch]) begin
                    sel_m[it.ch] = ~sel_m[it.ch];
                    exp_hi = 8;
                end
            end
        end
        tx_m = ~sel_m;
        chk("rst_pulse", 32'(hi), 32'(exp_hi));
        chk("sel_sgmii", 32'(sel_sgmii), 32'(sel_m));
        chk("tx_disable", 32'(tx_disable), 32'(tx_m));
        chk("id_err", 32'(id_err), 32'(err_m));
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            seen |= iic_req;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        repeat (3) @(negedge clk);
        chk("rst_phy", 32'(phy_rst), 32'h3);
        chk("rst_txdis", 32'(tx_disable), 32'h3);
        chk("rst_sel", 32'(sel_sgmii), 32'h0);
        chk("rst_req", 32'(iic_req), 32'h0);
        chk("rst_sigok", 32'(sig_ok), 32'h0);
        chk("rst_iderr", 32'(id_err), 32'h0);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            n++;
            seen |= iic_req;
            if (phy_rst == 2'b00) break;
        end
        chk("rst_width", 32'(n), 32'd8);
        chk("rst_no_req", 32'(seen), 32'd0);

        // Short glitch on channel 0 must not qualify
        sig_det[0] = 1'b1;
        repeat (10) @(negedge clk);
        sig_det[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            seen |= sig_ok[0] | iic_req;
        end
        chk("glitch", 32'(seen), 32'd0);

        // Both channels qualify together: ch0 then ch1
        @(negedge clk);
        sig_det = 2'b11;
        sb_q.push_back('{0, 8'h08, 0, 1'b0});
        sb_q.push_back('{1, 8'h00, 0, 1'b0});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sig_ok[0] && n < 40);
        chk("deb_latency", 32'(n), 32'd18);
        chk("both_ok", 32'(sig_ok), 32'h3);
        serve();
        serve();

        // Channel 0 re-read with same type: no reset pulse
        sig_det[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("sigok_fall", 32'(sig_ok[0]), 32'd0);
        sig_det[0] = 1'b1;
        sb_q.push_back('{0, 8'h08, 0, 1'b0});
        serve();

        // Next pair after ch0 was serviced starts with ch1
        requal(2'b11);
        sb_q.push_back('{1, 8'h00, 0, 1'b0});
        sb_q.push_back('{0, 8'h00, 0, 1'b0});
        serve();
        serve();

        // Read timeout on ch0, then I2C error on ch1
        requal(2'b01);
        sb_q.push_back('{0, 8'h08, 2, 1'b0});
        serve();
        quiet("idle_after_to", 40);
        requal(2'b10);
        sb_q.push_back('{1, 8'h08, 1, 1'b0});
        serve();

        // Good read clears sticky error on ch0
        requal(2'b01);
        sb_q.push_back('{0, 8'hF7, 0, 1'b0});
        serve();

        // Signal loss on ch1 during the read discards the result
        requal(2'b10);
        sb_q.push_back('{1, 8'h08, 0, 1'b1});
        serve();
        quiet("idle_after_drop", 30);

        // Reset in the middle of a request
        requal(2'b01);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = iic_req;
        end
        chk("mid_req_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(iic_req), 32'd0);
        chk("mid_rst_phy", 32'(phy_rst), 32'h3);
        chk("mid_rst_sel", 32'(sel_sgmii), 32'h0);
        chk("mid_rst_iderr", 32'(id_err), 32'h0);
        chk("mid_rst_sigok", 32'(sig_ok), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
